// File: rtl/nsum_pkg.sv
// Shared widths and FSM state type for the NSum feeder and the NSum stage.
package nsum_pkg;

  localparam int N_W   = 3;
  localparam int SUM_W = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

endpackage

// File: rtl/nsum_feeder_if.sv
// Request/issue bus between the producer, the feeder and the NSum stage.
interface nsum_feeder_if;
  import nsum_pkg::*;

  logic [N_W-1:0]   req_n;
  logic             req_valid;
  logic             req_ready;
  logic [N_W-1:0]   N;
  logic             N_valid;
  logic             sum_valid;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;
  logic             timeout;

  modport master (
    output req_n, req_valid, sum_valid,
    input  req_ready, N, N_valid, busy, fifo_count, timeout
  );

  modport slave (
    input  req_n, req_valid, sum_valid,
    output req_ready, N, N_valid, busy, fifo_count, timeout
  );

endinterface

// File: rtl/nsum_req_fifo.sv
// Request FIFO: power-of-two depth, pointers wrap naturally, no pass-through when full.
module nsum_req_fifo
  import nsum_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = N_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [W-1:0]     i_data,
  input  logic             i_pop,
  output logic [W-1:0]     o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nsum_feeder.sv
// Feeds queued N requests to the NSum stage one at a time, with a completion timeout.
//   state | meaning
//   IDLE  | waiting for a queued request; pops the head into N when one exists
//   ISSUE | N_valid strobe for one cycle
//   WAIT  | waiting for sum_valid, aborted with a timeout pulse after TIMEOUT cycles
module nsum_feeder
  import nsum_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  nsum_feeder_if.slave bus
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WCW-1:0]   r_wait_cnt;
  logic [N_W-1:0]   r_n;
  logic             w_pop;
  logic             w_full;
  logic             w_tc;
  logic [N_W-1:0]   w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_n_valid;
  logic             w_busy;
  logic             w_timeout;

  assign w_pop = (r_state == IDLE) && (w_count != '0);
  assign w_tc  = (r_wait_cnt == WCW'(TIMEOUT - 1));

  nsum_req_fifo #(
    .DEPTH (DEPTH),
    .W     (N_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.req_valid),
    .i_data  (bus.req_n),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_n_valid   = 1'b0;
    w_busy      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_count != '0) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_n_valid   = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        w_busy = 1'b1;
        if (bus.sum_valid) begin
          w_state_nxt = IDLE;
        end else if (w_tc) begin
          // a reset landing on the final wait cycle discards the WAIT silently
          w_timeout   = ~reset;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)      r_n <= '0;
    else if (w_pop) r_n <= w_head;
  end

  always_ff @(posedge clk) begin
    if (reset)                 r_wait_cnt <= '0;
    else if (r_state == ISSUE) r_wait_cnt <= '0;
    else if (r_state == WAIT)  r_wait_cnt <= r_wait_cnt + WCW'(1);
  end

  assign bus.req_ready  = ~w_full;
  assign bus.N          = r_n;
  assign bus.N_valid    = w_n_valid;
  assign bus.busy       = w_busy;
  assign bus.fifo_count = w_count;
  assign bus.timeout    = w_timeout;

endmodule

// File: doc/nsum_feeder.md
NSUM_FEEDER -- requirements
Module: nsum_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of request FIFO entries (power of two, 2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the maximum cycles spent in WAIT before abort.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_n  input  3  requested N value from the producer.
REQ-006 req_valid  input  1  req_n is valid this cycle.
REQ-007 req_ready  output  1  the FIFO can accept a request this cycle.
REQ-008 N  output  3  N value presented to the downstream NSum stage.
REQ-009 N_valid  output  1  one-cycle strobe that starts one NSum computation.
REQ-010 sum_valid  input  1  completion strobe from the NSum stage.
REQ-011 busy  output  1  high while in ISSUE or WAIT.
REQ-012 fifo_count  output  4  number of queued requests, range 0..DEPTH.
REQ-013 timeout  output  1  one-cycle pulse when a WAIT is aborted.

Function
REQ-014 Push SHALL occur on an edge where req_valid and req_ready are both high; req_ready SHALL be combinational, with req_ready = (fifo_count < DEPTH).
REQ-015 When the FIFO is full, req_ready SHALL be low even if a pop occurs in the same cycle; there is no full-FIFO pass-through.
REQ-016 A simultaneous push and pop with 0 < count < DEPTH SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-017 The FSM states SHALL be IDLE, ISSUE and WAIT, with one state transition per edge.
REQ-018 IDLE -> ISSUE: when fifo_count != 0, the SHALL pop the head into the N register on that edge.
REQ-019 IDLE with fifo_count == 0 SHALL remain in IDLE.
REQ-020 ISSUE SHALL assert N_valid high for exactly one cycle and then transition unconditionally to WAIT.
REQ-021 Entry into WAIT SHALL clear the wait counter.
REQ-022 WAIT with sum_valid high SHALL transition to IDLE.
REQ-023 WAIT with the wait counter at TIMEOUT-1 and sum_valid low SHALL pulse timeout for one cycle and transition to IDLE.
REQ-024 When sum_valid and the final timeout count coincide, sum_valid SHALL win and timeout SHALL NOT pulse.
REQ-025 sum_valid SHALL be ignored in IDLE and ISSUE.
REQ-026 N SHALL hold the last issued value between issues; N SHALL change only on the ISSUE-entry edge.
REQ-027 Latency: a request pushed into an empty FIFO while in IDLE at edge k SHALL produce N_valid high in the cycle after edge k+1.
REQ-028 Back-to-back requests SHALL always pass through IDLE, giving at least one IDLE cycle between sum_valid and the next N_valid.
REQ-029 Pointers SHALL wrap modulo DEPTH, and fifo_count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-030 When reset is high at an edge, the block SHALL go to state IDLE and clear all of the following: fifo_count, pointers, N, N_valid, busy, timeout and the wait counter.
REQ-031 Reset SHALL discard queued requests and any in-flight WAIT without emitting a timeout pulse.
REQ-032 Reset SHALL take priority over push, pop and every FSM transition in the same cycle.
REQ-033 req_ready SHALL be high in the first cycle after reset deasserts.

Structure
REQ-034 Package nsum_pkg SHALL hold N_W=3, SUM_W=4 and the state enum (IDLE, ISSUE, WAIT), shared with NSum and its benches.
REQ-035 The FIFO SHALL be a separate sub-module nsum_req_fifo (parameters DEPTH and width N_W), exposing push, pop, head, count and full.
REQ-036 The FSM, wait counter and N register SHALL reside in nsum_feeder.

Verification
REQ-037 The bench SHALL cover: after reset, push req_n=5, then sum_valid 6 cycles after N_valid -> N=5, one-cycle N_valid, busy high from ISSUE through WAIT, return to IDLE.
REQ-038 The bench SHALL cover: push 5,4,3,2 back-to-back, then a 5th push -> req_ready low at fifo_count=4; issues appear in order 5,4,3,2, each one after the prior sum_valid plus one IDLE cycle.
REQ-039 The bench SHALL cover: issue N=4 with no sum_valid -> timeout pulses 16 cycles after WAIT entry; the next queued entry issues afterwards.
REQ-040 The bench SHALL cover: sum_valid coinciding with the final timeout cycle -> no timeout pulse, normal return to IDLE.
REQ-041 The bench SHALL cover: reset asserted mid-WAIT with 2 entries queued -> fifo_count=0, N=0, N_valid=0, no timeout pulse, no further issues.
REQ-042 The bench SHALL cover: push and pop on the same edge at fifo_count=2 -> fifo_count stays 2 and order is preserved.
